// File: rtl/bg_tile_scheduler.sv
// bg_tile_scheduler: maps raster pixels onto the play-field grid, sequences the
// background sprite ROM (grid lookup -> ROM read -> aligned pixel, 4-cycle
// latency) and lends idle ROM slots to an auxiliary requester.
// Optional build macro BG_STATE_CHECK_EN: out-of-range tile states (> 12) are
// replaced by 0 (grass); display-path hits latch the sticky tile_err flag.
module bg_tile_scheduler #(
   parameter int         FIELD_X0   = 95,
   parameter int         FIELD_Y0   = 45,
   parameter int         GRID_W     = 15,
   parameter int         GRID_H     = 13,
   parameter logic [3:0] BORDER_IDX = 4'h0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       disp_valid,
   input  logic [9:0] disp_x,
   input  logic [9:0] disp_y,
   output logic [7:0] grid_addr,
   input  logic [3:0] grid_data,
   output logic [3:0] rom_state,
   output logic [9:0] rom_addr,
   input  logic [3:0] rom_data,
   output logic       pix_valid,
   output logic [3:0] pix_data,
   output logic       pix_in_field,
   input  logic       aux_req,
   input  logic [3:0] aux_state,
   input  logic [9:0] aux_addr,
   output logic       aux_gnt,
   output logic       aux_rvalid,
   output logic [3:0] aux_rdata,
   output logic       tile_err
);

   localparam int         TILE      = 30;
   localparam logic [9:0] X_LO      = 10'(FIELD_X0);
   localparam logic [9:0] X_HI      = 10'(FIELD_X0 + TILE * GRID_W);
   localparam logic [9:0] Y_LO      = 10'(FIELD_Y0);
   localparam logic [9:0] Y_HI      = 10'(FIELD_Y0 + TILE * GRID_H);
   localparam logic [4:0] TILE_LAST = 5'(TILE - 1);

   // Position trackers: cell (col,row) and offset inside the tile (ox,oy).
   logic [3:0] col, row, col_n, row_n;
   logic [4:0] ox, oy, ox_n, oy_n;

   // Pipeline stage state.
   logic       s1_valid, s1_in_field;
   logic [4:0] s1_ox, s1_oy;
   logic       s2_valid, s2_in_field;
   logic [9:0] disp_addr;
   logic       s3_valid, s3_in_field;
   logic       aux_pend;
   logic [3:0] last_state;
   logic [9:0] last_addr;

   logic       in_field, take, disp_own;
   logic [3:0] disp_state, aux_state_ok;

   assign in_field = (disp_x >= X_LO) && (disp_x < X_HI) &&
                     (disp_y >= Y_LO) && (disp_y < Y_HI);
   assign take     = disp_valid & in_field;

   // Counter-based raster tracking: the next cell/offset for the incoming pixel.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      col_n = col;
      row_n = row;
      ox_n  = ox;
      oy_n  = oy;
      if (disp_x == X_LO) begin
         col_n = '0;
         ox_n  = '0;
         if (disp_y == Y_LO) begin
            row_n = '0;
            oy_n  = '0;
         end else if (oy == TILE_LAST) begin
            oy_n  = '0;
            row_n = row + 4'd1;
         end else begin
            oy_n  = oy + 5'd1;
         end
      end else if (ox == TILE_LAST) begin
         ox_n  = '0;
         col_n = col + 4'd1;
      end else begin
         ox_n  = ox + 5'd1;
      end
   end

   // S1: commit the trackers and register the grid address for in-field pixels.
   always_ff @(posedge clk) begin
      // NOTE: all state is flops updated with <=; every register is reset, no memories here.
      if (reset) begin
         col <= '0; row <= '0; ox <= '0; oy <= '0;
         s1_valid    <= 1'b0;
         s1_in_field <= 1'b0;
         s1_ox       <= '0;
         s1_oy       <= '0;
         grid_addr   <= '0;
      end else begin
         s1_valid    <= disp_valid;
         s1_in_field <= in_field;
         if (take) begin
            col       <= col_n;
            row       <= row_n;
            ox        <= ox_n;
            oy        <= oy_n;
            s1_ox     <= ox_n;
            s1_oy     <= oy_n;
            grid_addr <= 8'(row_n) * 8'(GRID_W) + 8'(col_n);
         end
      end
   end

   // S2: register the in-tile ROM address alongside the grid lookup.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid    <= 1'b0;
         s2_in_field <= 1'b0;
         disp_addr   <= '0;
      end else begin
         s2_valid    <= s1_valid;
         s2_in_field <= s1_in_field;
         if (s1_valid && s1_in_field)
            disp_addr <= 10'(s1_oy) * 10'(TILE) + 10'(s1_ox);
      end
   end

`ifdef BG_STATE_CHECK_EN
   localparam logic [3:0] MAX_STATE = 4'd12;
   assign disp_state   = (grid_data > MAX_STATE) ? 4'd0 : grid_data;
   assign aux_state_ok = (aux_state > MAX_STATE) ? 4'd0 : aux_state;

   // Sticky flag for illegal display-path tile states, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         tile_err <= 1'b0;
      else if (disp_own && (grid_data > MAX_STATE))
         tile_err <= 1'b1;
   end
`else
   assign disp_state   = grid_data;
   assign aux_state_ok = aux_state;
   assign tile_err     = 1'b0;
`endif

   // Only an in-field display pixel in S2 claims the ROM; display always wins.
   assign disp_own = s2_valid & s2_in_field;
   assign aux_gnt  = aux_req & ~disp_own & ~reset;

   // ROM port mux: display, then granted aux, otherwise hold the last request.
   always_comb begin
      rom_state = last_state;
      rom_addr  = last_addr;
      if (disp_own) begin
         rom_state = disp_state;
         rom_addr  = disp_addr;
      end else if (aux_gnt) begin
         rom_state = aux_state_ok;
         rom_addr  = aux_addr;
      end
   end

   // Remember what the ROM port last carried so idle slots hold it.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_state <= '0;
         last_addr  <= '0;
      end else begin
         last_state <= rom_state;
         last_addr  <= rom_addr;
      end
   end

   // S3/S4: track ROM latency, then register the aligned pixel and aux reply.
   always_ff @(posedge clk) begin
      if (reset) begin
         s3_valid     <= 1'b0;
         s3_in_field  <= 1'b0;
         aux_pend     <= 1'b0;
         pix_valid    <= 1'b0;
         pix_data     <= '0;
         pix_in_field <= 1'b0;
         aux_rvalid   <= 1'b0;
         aux_rdata    <= '0;
      end else begin
         s3_valid    <= s2_valid;
         s3_in_field <= s2_in_field;
         aux_pend    <= aux_gnt;
         pix_valid   <= s3_valid;
         aux_rvalid  <= aux_pend;
         if (s3_valid) begin
            pix_data     <= s3_in_field ? rom_data : BORDER_IDX;
            pix_in_field <= s3_in_field;
         end
         if (aux_pend)
            aux_rdata <= rom_data;
      end
   end

endmodule

// File: tb/tb_bg_tile_scheduler.sv
// Self-checking bench for bg_tile_scheduler: grid and ROM behavioural models,
// a division-based reference scoreboard, a table of hand-computed tile
// boundary vectors, and directed sequences for aux sharing, reset and states.
module tb_bg_tile_scheduler;

   localparam int X0 = 95;
   localparam int Y0 = 45;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       disp_valid = 1'b0;
   logic [9:0] disp_x = '0;
   logic [9:0] disp_y = '0;
   logic [7:0] grid_addr;
   logic [3:0] grid_data = '0;
   logic [3:0] rom_state;
   logic [9:0] rom_addr;
   logic [3:0] rom_data = '0;
   logic       pix_valid;
   logic [3:0] pix_data;
   logic       pix_in_field;
   logic       aux_req = 1'b0;
   logic [3:0] aux_state = '0;
   logic [9:0] aux_addr = '0;
   logic       aux_gnt;
   logic       aux_rvalid;
   logic [3:0] aux_rdata;
   logic       tile_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit sb_en    = 1'b0;

   bg_tile_scheduler dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_x(disp_x), .disp_y(disp_y),
      .grid_addr(grid_addr), .grid_data(grid_data),
      .rom_state(rom_state), .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_in_field(pix_in_field),
      .aux_req(aux_req), .aux_state(aux_state), .aux_addr(aux_addr),
      .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .tile_err(tile_err)
   );

   always #5 clk = ~clk;

`ifdef BG_STATE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // Behavioural memories: 1-cycle registered reads.
   logic [3:0] grid_mem [0:255];

   function automatic logic [3:0] rom_fn(input logic [3:0] s, input logic [9:0] a);
      int v;
      v = int'(s) * 3 + int'(a) + int'(a >> 4);
      return v[3:0];
   endfunction

   function automatic logic [3:0] filt(input logic [3:0] s);
      return (CHECK_EN && s > 4'd12) ? 4'd0 : s;
   endfunction

   always @(posedge clk) grid_data <= grid_mem[grid_addr];
   always @(posedge clk) rom_data  <= rom_fn(rom_state, rom_addr);

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: direct division of screen coordinates.
   typedef struct {
      logic valid;
      logic in_field;
      int   ga;
      int   ra;
   } stage_t;

   function automatic stage_t model(input logic v, input logic [9:0] x, input logic [9:0] y);
      stage_t s;
      int dx, dy;
      dx = int'(x) - X0;
      dy = int'(y) - Y0;
      s.valid    = v;
      s.in_field = (dx >= 0) && (dx < 450) && (dy >= 0) && (dy < 390);
      s.ga = s.in_field ? (dy / 30) * 15 + dx / 30 : 0;
      s.ra = s.in_field ? (dy % 30) * 30 + dx % 30 : 0;
      return s;
   endfunction

   stage_t p1, p2, p3, p4;
   int     exp_ga;

   always @(posedge clk) begin
      if (reset) begin
         p1 <= '{1'b0, 1'b0, 0, 0};
         p2 <= '{1'b0, 1'b0, 0, 0};
         p3 <= '{1'b0, 1'b0, 0, 0};
         p4 <= '{1'b0, 1'b0, 0, 0};
         exp_ga <= 0;
      end else begin
         p1 <= model(disp_valid, disp_x, disp_y);
         p2 <= p1;
         p3 <= p2;
         p4 <= p3;
         if (disp_valid && model(disp_valid, disp_x, disp_y).in_field)
            exp_ga <= model(disp_valid, disp_x, disp_y).ga;
      end
   end

   // Scoreboard compares every stage against the reference model mid-cycle.
   always @(negedge clk) begin
      if (sb_en && !reset) begin
         check("sb_grid_addr", int'(grid_addr), exp_ga);
         if (p2.valid && p2.in_field) begin
            check("sb_rom_state", int'(rom_state), int'(filt(grid_mem[p2.ga])));
            check("sb_rom_addr", int'(rom_addr), p2.ra);
            check("sb_aux_blocked", int'(aux_gnt), 0);
         end
         check("sb_pix_valid", int'(pix_valid), int'(p4.valid));
         if (p4.valid) begin
            check("sb_pix_in_field", int'(pix_in_field), int'(p4.in_field));
            check("sb_pix_data", int'(pix_data),
                  p4.in_field ? int'(rom_fn(filt(grid_mem[p4.ga]), 10'(p4.ra))) : 0);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int x, input int y);
      disp_valid = v;
      disp_x     = 10'(x);
      disp_y     = 10'(y);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_outs_a"}, int'({grid_addr, rom_state, rom_addr, pix_valid, pix_data}), 0);
      check({tag, "_outs_b"}, int'({pix_in_field, aux_gnt, aux_rvalid, aux_rdata, tile_err}), 0);
   endtask

   typedef struct {
      int y_lo, y_hi, x_lo, x_hi;
      int ga;
      int ra;   // -1: rom_addr not owned by display
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) grid_mem[i] = 4'((i * 7 + 2) % 13);

      // Last pixel of each run is checked against hand-computed addresses.
      vecs[0] = '{45, 45,   95,  95,   0,   0};   // origin
      vecs[1] = '{45, 45,   96, 124,   0,  29};   // last column of tile 0
      vecs[2] = '{45, 45,  125, 125,   1,   0};   // first pixel of tile 1
      vecs[3] = '{45, 45,  126, 544,  14,  29};   // right edge of line
      vecs[4] = '{46, 75,   95,  95,  15,   0};   // row wrap at y=75
      vecs[5] = '{76, 433,  95,  95, 180, 840};   // second-last line
      vecs[6] = '{434, 434, 95, 544, 194, 899};   // bottom-right corner
      vecs[7] = '{10, 10,   10,  10, 194,  -1};   // out-of-field holds

      // Reset state
      reset = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check_zero("reset");
      next_cycle();
      reset = 1'b0;
      sb_en = 1'b1;

      // Origin pixel end to end
      drive(1, 95, 45);
      next_cycle();
      drive(0, 0, 0);
      @(negedge clk); check("origin_grid_addr", int'(grid_addr), 0); next_cycle();
      @(negedge clk); check("origin_rom_state", int'(rom_state), 2);
                      check("origin_rom_addr", int'(rom_addr), 0); next_cycle();
      @(negedge clk); check("origin_pix_early", int'(pix_valid), 0); next_cycle();
      @(negedge clk); check("origin_pix_valid", int'(pix_valid), 1);
                      check("origin_in_field", int'(pix_in_field), 1);
                      check("origin_pix_data", int'(pix_data), int'(rom_fn(4'd2, 10'd0)));
      next_cycle();

      // Table-driven tile boundary vectors
      for (int i = 0; i < NV; i++) begin
         for (int y = vecs[i].y_lo; y <= vecs[i].y_hi; y++)
            for (int x = vecs[i].x_lo; x <= vecs[i].x_hi; x++) begin
               drive(1, x, y);
               next_cycle();
            end
         drive(0, 0, 0);
         @(negedge clk);
         check($sformatf("vec%0d_grid_addr", i), int'(grid_addr), vecs[i].ga);
         next_cycle();
         @(negedge clk);
         if (vecs[i].ra >= 0)
            check($sformatf("vec%0d_rom_addr", i), int'(rom_addr), vecs[i].ra);
         next_cycle();
      end

      // Out-of-field pixel frees its S2 slot for the waiting aux request
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: drive(1, 95, 45);
            1: drive(1, 96, 45);
            2: begin drive(1, 10, 10); aux_req = 1'b1; aux_state = 4'd9; aux_addr = 10'd777; end
            3: drive(1, 97, 45);
            5: begin drive(0, 0, 0); aux_req = 1'b0; end
            default: drive(0, 0, 0);
         endcase
         @(negedge clk);
         if (k == 2 || k == 3) check($sformatf("oof_gnt_blocked%0d", k), int'(aux_gnt), 0);
         if (k == 4) begin
            check("oof_gnt", int'(aux_gnt), 1);
            check("oof_rom_state", int'(rom_state), 9);
            check("oof_rom_addr", int'(rom_addr), 777);
         end
         if (k == 6) begin
            check("oof_pix_valid", int'(pix_valid), 1);
            check("oof_in_field", int'(pix_in_field), 0);
            check("oof_border", int'(pix_data), 0);
            check("oof_rvalid", int'(aux_rvalid), 1);
            check("oof_rdata", int'(aux_rdata), int'(rom_fn(4'd9, 10'd777)));
         end
         if (k == 7) begin
            check("idle_hold_state", int'(rom_state), int'(filt(grid_mem[0])));
            check("idle_hold_addr", int'(rom_addr), 2);
            check("oof_rvalid_once", int'(aux_rvalid), 0);
         end
         next_cycle();
      end

      // Contention: aux waits out a full active line
      for (int k = 0; k < 455; k++) begin
         if (k < 450) drive(1, 95 + k, 45);
         else         drive(0, 0, 0);
         if (k == 2) begin aux_req = 1'b1; aux_state = 4'd5; aux_addr = 10'd123; end
         if (k == 453) aux_req = 1'b0;
         @(negedge clk);
         if (k >= 2 && k <= 452) check("cont_gnt", int'(aux_gnt), (k == 452) ? 1 : 0);
         if (k == 453) check("cont_rvalid_early", int'(aux_rvalid), 0);
         if (k == 454) begin
            check("cont_rvalid", int'(aux_rvalid), 1);
            check("cont_rdata", int'(aux_rdata), int'(rom_fn(4'd5, 10'd123)));
         end
         next_cycle();
      end

      // Reset mid-stream with pixels and an aux read in flight
      for (int k = 0; k < 11; k++) begin
         case (k)
            0: drive(1, 10, 10);
            1: drive(1, 95, 45);
            2: begin drive(1, 96, 45); aux_req = 1'b1; aux_state = 4'd3; aux_addr = 10'd50; end
            3: begin drive(1, 97, 45); aux_req = 1'b0; reset = 1'b1; end
            6: begin drive(0, 0, 0); reset = 1'b0; end
            default: drive(0, 0, 0);
         endcase
         @(negedge clk);
         if (k == 2) check("rst_aux_gnt", int'(aux_gnt), 1);
         if (k >= 4 && k <= 6) check_zero($sformatf("midrst%0d", k));
         if (k >= 7) begin
            check("postrst_pix_valid", int'(pix_valid), 0);
            check("postrst_aux_rvalid", int'(aux_rvalid), 0);
         end
         next_cycle();
      end

      // Illegal tile state handling
      grid_mem[0] = 4'd13;
      drive(1, 95, 45);
      next_cycle();
      drive(0, 0, 0);
      @(negedge clk); next_cycle();
      @(negedge clk); check("bad_rom_state", int'(rom_state), CHECK_EN ? 0 : 13); next_cycle();
      @(negedge clk); check("bad_tile_err", int'(tile_err), int'(CHECK_EN));
      repeat (4) next_cycle();
      @(negedge clk); check("tile_err_sticky", int'(tile_err), int'(CHECK_EN)); next_cycle();
      aux_req = 1'b1; aux_state = 4'd14; aux_addr = 10'd5;
      @(negedge clk); check("bad_aux_gnt", int'(aux_gnt), 1);
                      check("bad_aux_state", int'(rom_state), CHECK_EN ? 0 : 14);
      next_cycle();
      aux_req = 1'b0;
      @(negedge clk); next_cycle();
      @(negedge clk); check("bad_aux_rvalid", int'(aux_rvalid), 1);
                      check("bad_aux_rdata", int'(aux_rdata), int'(rom_fn(filt(4'd14), 10'd5)));
                      check("tile_err_after_aux", int'(tile_err), int'(CHECK_EN));
      next_cycle();
      reset = 1'b1;
      next_cycle();
      @(negedge clk); check("tile_err_cleared", int'(tile_err), 0);
      next_cycle();
      reset = 1'b0;
      grid_mem[0] = 4'd2;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
